// File: rtl/tcp_tx_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tcp_tx_pkt_gen: reads per-flow TCP state and emits one segment descriptor  |
// | per scheduler request, writing back the advanced sequence number.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tcp_tx_pkt_gen #(
  parameter int FLOWID_W = 8,
  parameter int TX_PTR_W = 16,
  parameter int MSS      = 1460
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sched_cmd_val,
  input  logic [FLOWID_W-1:0] sched_cmd_flowid,
  input  logic                sched_cmd_data,
  output logic                sched_cmd_rdy,
  output logic                state_rd_req_val,
  output logic [FLOWID_W-1:0] state_rd_req_flowid,
  input  logic                state_rd_resp_val,
  input  logic [31:0]         state_rd_resp_seq,
  input  logic [31:0]         state_rd_resp_ack,
  input  logic [15:0]         state_rd_resp_their_win,
  input  logic [15:0]         state_rd_resp_our_win,
  input  logic [TX_PTR_W:0]   state_rd_resp_tail,
  output logic                seq_wr_val,
  output logic [FLOWID_W-1:0] seq_wr_flowid,
  output logic [31:0]         seq_wr_data,
  output logic                pkt_val,
  input  logic                pkt_rdy,
  output logic [FLOWID_W-1:0] pkt_flowid,
  output logic [31:0]         pkt_seq,
  output logic [31:0]         pkt_ack,
  output logic [15:0]         pkt_win,
  output logic [7:0]          pkt_flags,
  output logic [TX_PTR_W-1:0] pkt_payload_ptr,
  output logic [15:0]         pkt_payload_len
);

  localparam logic [31:0] c_MSS_32    = 32'(MSS);
  localparam logic [7:0]  c_FLAG_ACK  = 8'h10;
  localparam logic [7:0]  c_FLAG_APSH = 8'h18;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_CALC    = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_cmd_rdy;
  logic                  r_rd_req_val;
  logic [FLOWID_W-1:0]   r_flowid;
  logic                  r_data;
  logic [31:0]           r_seq;
  logic [31:0]           r_ack;
  logic [15:0]           r_their_win;
  logic [15:0]           r_our_win;
  logic [TX_PTR_W:0]     r_tail;
  logic                  r_pkt_val;
  logic [FLOWID_W-1:0]   r_pkt_flowid;
  logic [31:0]           r_pkt_seq;
  logic [31:0]           r_pkt_ack;
  logic [15:0]           r_pkt_win;
  logic [7:0]            r_pkt_flags;
  logic [TX_PTR_W-1:0]   r_pkt_ptr;
  logic [15:0]           r_pkt_len;
  logic                  r_len_nz;
  logic [31:0]           r_seq_next;

  logic [TX_PTR_W:0]     w_unsent;
  logic [31:0]           w_unsent32;
  logic [31:0]           w_win32;
  logic [31:0]           w_len32;

  // Pointer difference includes the wrap bit, so it is naturally modular.
  assign w_unsent   = r_tail - r_seq[TX_PTR_W:0];
  assign w_unsent32 = 32'(w_unsent);
  assign w_win32    = {16'h0000, r_their_win};

  always_comb begin
    w_len32 = c_MSS_32;
    if (w_unsent32 < w_len32) w_len32 = w_unsent32;
    if (w_win32 < w_len32)    w_len32 = w_win32;
    if (!r_data)              w_len32 = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd_rdy    <= 1'b1;
      r_rd_req_val <= 1'b0;
      r_flowid     <= '0;
      r_data       <= 1'b0;
      r_seq        <= '0;
      r_ack        <= '0;
      r_their_win  <= '0;
      r_our_win    <= '0;
      r_tail       <= '0;
      r_pkt_val    <= 1'b0;
      r_pkt_flowid <= '0;
      r_pkt_seq    <= '0;
      r_pkt_ack    <= '0;
      r_pkt_win    <= '0;
      r_pkt_flags  <= '0;
      r_pkt_ptr    <= '0;
      r_pkt_len    <= '0;
      r_len_nz     <= 1'b0;
      r_seq_next   <= '0;
    end else begin
      r_rd_req_val <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sched_cmd_val) begin
            r_flowid     <= sched_cmd_flowid;
            r_data       <= sched_cmd_data;
            r_cmd_rdy    <= 1'b0;
            r_rd_req_val <= 1'b1;
            r_state      <= S_RD_REQ;
          end
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (state_rd_resp_val) begin
            r_seq       <= state_rd_resp_seq;
            r_ack       <= state_rd_resp_ack;
            r_their_win <= state_rd_resp_their_win;
            r_our_win   <= state_rd_resp_our_win;
            r_tail      <= state_rd_resp_tail;
            r_state     <= S_CALC;
          end
        end
        S_CALC: begin
          r_pkt_val    <= 1'b1;
          r_pkt_flowid <= r_flowid;
          r_pkt_seq    <= r_seq;
          r_pkt_ack    <= r_ack;
          r_pkt_win    <= r_our_win;
          r_pkt_ptr    <= r_seq[TX_PTR_W-1:0];
          r_pkt_len    <= w_len32[15:0];
          r_pkt_flags  <= (w_len32 != 32'h0) ? c_FLAG_APSH : c_FLAG_ACK;
          r_len_nz     <= (w_len32 != 32'h0);
          r_seq_next   <= r_seq + w_len32;
          r_state      <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (pkt_rdy) begin
            r_pkt_val <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cmd_rdy <= 1'b1;
          r_pkt_val <= 1'b0;
        end
      endcase
    end
  end

  assign sched_cmd_rdy       = r_cmd_rdy;
  assign state_rd_req_val    = r_rd_req_val;
  assign state_rd_req_flowid = r_flowid;

  // Writeback coincides with the descriptor handshake; a reset that cycle drops it.
  assign seq_wr_val    = r_pkt_val & pkt_rdy & r_len_nz & ~rst;
  assign seq_wr_flowid = r_flowid;
  assign seq_wr_data   = r_seq_next;

  assign pkt_val         = r_pkt_val;
  assign pkt_flowid      = r_pkt_flowid;
  assign pkt_seq         = r_pkt_seq;
  assign pkt_ack         = r_pkt_ack;
  assign pkt_win         = r_pkt_win;
  assign pkt_flags       = r_pkt_flags;
  assign pkt_payload_ptr = r_pkt_ptr;
  assign pkt_payload_len = r_pkt_len;

endmodule
`default_nettype wire

// File: doc/tcp_tx_pkt_gen.md
TCP_TX_PKT_GEN -- requirements
Module: tcp_tx_pkt_gen

Interface
REQ-001 The block SHALL have parameter FLOWID_W, default 8, flow ID width.
REQ-002 The block SHALL have parameter TX_PTR_W, default 16, TX payload buffer index width; pointers are TX_PTR_W+1 bits wide, including a wrap bit.
REQ-003 The block SHALL have parameter MSS, default 1460, maximum payload bytes per segment.
REQ-004 Ports SHALL be:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sched_cmd_val  in  1  send request valid
sched_cmd_flowid  in  FLOWID_W  flow to service
sched_cmd_data  in  1  data pending (0 = pure ACK)
sched_cmd_rdy  out  1  request accepted
state_rd_req_val  out  1  flow state read request
state_rd_req_flowid  out  FLOWID_W  read address
state_rd_resp_val  in  1  read data valid
state_rd_resp_seq  in  32  our_seq_num
state_rd_resp_ack  in  32  their_ack_num
state_rd_resp_their_win  in  16  peer window
state_rd_resp_our_win  in  16  our advertised window
state_rd_resp_tail  in  TX_PTR_W+1  TX tail pointer
seq_wr_val  out  1  sequence-number writeback strobe
seq_wr_flowid  out  FLOWID_W  writeback address
seq_wr_data  out  32  new our_seq_num
pkt_val  out  1  segment descriptor valid
pkt_rdy  in  1  downstream ready
pkt_flowid  out  FLOWID_W  flow
pkt_seq  out  32  header sequence number
pkt_ack  out  32  header ACK number
pkt_win  out  16  header window
pkt_flags  out  8  TCP flags
pkt_payload_ptr  out  TX_PTR_W  payload start index
pkt_payload_len  out  16  payload bytes

Function
REQ-005 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, CALC, OUTPUT.
REQ-006 sched_cmd_rdy SHALL be 1 only in IDLE; on val&rdy, the block SHALL latch flowid and data, then go to RD_REQ.
REQ-007 RD_REQ SHALL assert state_rd_req_val for exactly one cycle with the latched flowid, then go to RD_WAIT.
REQ-008 RD_WAIT SHALL hold until state_rd_resp_val, latch all resp fields, then go to CALC.
REQ-009 CALC (one cycle) SHALL compute unsent = (tail - seq[TX_PTR_W:0]) mod 2^(TX_PTR_W+1).
REQ-010 CALC SHALL compute len = data ? min(unsent, their_win, MSS) : 0; all compares SHALL be unsigned, zero-extended to 32 bits.
REQ-011 CALC SHALL register pkt_seq = seq, pkt_ack = ack, pkt_win = our_win, pkt_payload_ptr = seq[TX_PTR_W-1:0], pkt_payload_len = len.
REQ-012 CALC SHALL register pkt_flags = ACK (0x10), or ACK|PSH (0x18) when len != 0; it then goes to OUTPUT.
REQ-013 OUTPUT SHALL assert pkt_val with all pkt_* held stable until pkt_rdy.
REQ-014 On the pkt_val&pkt_rdy cycle, if len != 0, the block SHALL pulse seq_wr_val for one cycle with seq_wr_data = (seq + len) mod 2^32 and seq_wr_flowid = latched flowid; it then returns to IDLE.
REQ-015 With no stalls, the block SHALL assert pkt_val 4 cycles after the request handshake when state_rd_resp_val is returned the cycle after the read request; one flow SHALL be in flight at a time.
REQ-016 Boundary cases:
- unsent = 0 with data = 1 → pure ACK, len 0, no writeback.
- their_win = 0 → len 0, no writeback.
- tail wrap bit differs from the seq wrap bit → the modular difference SHALL be used.
- seq + len crossing 2^32 → wrap.
- sched_cmd_val outside IDLE → ignored, rdy stays 0.

Reset
REQ-017 rst SHALL force IDLE on the next edge, abandoning any in-flight flow without writeback.
REQ-018 During and immediately after reset, sched_cmd_rdy SHALL be 1 and state_rd_req_val, seq_wr_val and pkt_val SHALL be 0.
REQ-019 All other outputs SHALL reset to 0.

Verification
REQ-020 Basic data: data=1, seq=0x100, tail=0x300, their_win=0xFFFF → len 512, ptr 0x100, flags 0x18, seq_wr_data 0x300.
REQ-021 MSS and window clamp: unsent 4000, their_win 0xFFFF → len 1460; then unsent 4000, their_win 100 → len 100.
REQ-022 Pure ACK: data=0, unsent 512 → len 0, flags 0x10, seq_wr_val never asserted.
REQ-023 Wrap: TX_PTR_W=16, seq=0xFFFF_FFF0, tail=0x0_0010 → unsent 0x20, len 32, seq_wr_data 0x0000_0010.
REQ-024 Backpressure: pkt_rdy low for 10 cycles → pkt_* stable, sched_cmd_rdy 0, single seq_wr pulse on the handshake cycle.
REQ-025 Mid-op reset: assert rst in RD_WAIT → no pkt_val, no seq_wr_val; sched_cmd_rdy 1 after reset deasserts.
